// File: rtl/subtractor_pkg.sv
// Shared definitions for the registered sign-magnitude subtractor.
//
// Contents:
//   DEFAULT_WIDTH  - default operand/result width
//   sm_result_t    - sign-magnitude result at the default width
//   abs_diff()     - sign-magnitude |a - b| at the default width, for reference modelling
package subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic                     sign;
    logic [DEFAULT_WIDTH-1:0] mag;
  } sm_result_t;

  function automatic sm_result_t abs_diff(input logic [DEFAULT_WIDTH-1:0] a,
                                          input logic [DEFAULT_WIDTH-1:0] b);
    logic [DEFAULT_WIDTH:0] d;
    sm_result_t             r;
    d      = {1'b0, a} - {1'b0, b};
    r.sign = d[DEFAULT_WIDTH];
    r.mag  = d[DEFAULT_WIDTH] ? (b - a) : d[DEFAULT_WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/subtractor_abs_diff_comb.sv
// Combinational borrow-chain subtractor producing |a - b| and the borrow.
//
// Ports:
//   a      in  WIDTH  minuend, unsigned
//   b      in  WIDTH  subtrahend, unsigned
//   mag    out WIDTH  magnitude of a - b
//   borrow out 1      1 when a < b
module abs_diff_comb import subtractor_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mag,
  output logic             borrow
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("abs_diff_comb: WIDTH must be in 2..32");
  end

  logic [WIDTH:0]   bchain;
  logic [WIDTH-1:0] diff;

  assign bchain[0] = 1'b0;

  // Ripple borrow: bit i borrows out when a<b locally, or when equal and a borrow comes in.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign diff[i]     = a[i] ^ b[i] ^ bchain[i];
    assign bchain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bchain[i]);
  end

  assign borrow = bchain[WIDTH];

  // A negative difference is the two's complement of diff; it always fits in WIDTH bits.
  assign mag = borrow ? (~diff + WIDTH'(1)) : diff;

endmodule

// File: rtl/subtractor.sv
// Registered unsigned subtractor with sign-magnitude result, one cycle latency.
//
// Ports:
//   clk       in  1      clock, rising edge
//   rst_n     in  1      asynchronous active-low reset
//   in_valid  in  1      a and b valid this cycle
//   a         in  WIDTH  minuend, unsigned
//   b         in  WIDTH  subtrahend, unsigned
//   out_valid out 1      result/sign updated on the last edge
//   result    out WIDTH  |a - b|
//   zero      out 1      a == b for the captured pair (only with SUBTRACTOR_ZERO_FLAG_EN)
//   sign      out 1      1 when a < b
//
// Build option: define SUBTRACTOR_ZERO_FLAG_EN to add the registered zero flag.
module subtractor import subtractor_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
`ifdef SUBTRACTOR_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             sign
);

  logic [WIDTH-1:0] mag;
  logic             borrow;

  abs_diff_comb #(
    .WIDTH (WIDTH)
  ) u_abs_diff_comb (
    .a      (a),
    .b      (b),
    .mag    (mag),
    .borrow (borrow)
  );

  logic             valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             sign_d, sign_q;

  // Operands are only looked at when in_valid is high, so X on idle inputs never reaches state.
  always_comb begin
    result_d = result_q;
    sign_d   = sign_q;
    if (in_valid) begin
      result_d = mag;
      sign_d   = borrow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      sign_q   <= 1'b0;
    end else begin
      valid_q  <= in_valid;
      result_q <= result_d;
      sign_q   <= sign_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign sign      = sign_q;

`ifdef SUBTRACTOR_ZERO_FLAG_EN
  logic zero_d, zero_q;

  always_comb begin
    zero_d = zero_q;
    if (in_valid) begin
      zero_d = ~|mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_subtractor.sv
// Self-checking bench for subtractor: directed cases plus randomized streaming
// against an integer-arithmetic reference model.
module tb_subtractor;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned VW    = WIDTH + 3;  // {out_valid, sign, zero, result}

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             sign;
`ifdef SUBTRACTOR_ZERO_FLAG_EN
  logic             zero;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  subtractor #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
`ifdef SUBTRACTOR_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .sign      (sign)
  );

  // Observed outputs packed as {out_valid, sign, zero, result}; zero reads 0 when absent.
  function automatic logic [VW-1:0] obs();
    logic z;
`ifdef SUBTRACTOR_ZERO_FLAG_EN
    z = zero;
`else
    z = 1'b0;
`endif
    return {out_valid, sign, z, result};
  endfunction

  function automatic logic [VW-1:0] pack_exp(input logic v, input logic s, input logic z,
                                             input int unsigned m);
    logic zz;
`ifdef SUBTRACTOR_ZERO_FLAG_EN
    zz = z;
`else
    zz = 1'b0;
`endif
    return {v, s, zz, m[WIDTH-1:0]};
  endfunction

  // Reference: signed integer difference, then sign and absolute value.
  function automatic logic [VW-1:0] model(input int unsigned x, input int unsigned y);
    int d;
    d = int'(x) - int'(y);
    if (d < 0) return pack_exp(1'b1, 1'b1, 1'b0, int'(-d));
    return pack_exp(1'b1, 1'b0, d == 0, d);
  endfunction

  task automatic test_reset();
    logic [VW-1:0] e;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      @(posedge clk); #1;
      tests++;
      if (obs() !== '0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs(), {VW{1'b0}});
      end
    end
    // Release just after an edge: the next edge is the first capture.
    rst_n = 1'b1;
    a     = 4'd9;
    b     = 4'd4;
    @(posedge clk); #1;
    e = pack_exp(1'b1, 1'b0, 1'b0, 5);
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL first_capture: got %b expected %b", obs(), e);
    end
    // Mid-cycle asynchronous assertion clears outputs before any edge.
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (obs() !== '0) begin
      fails++;
      $display("FAIL async_reset: got %b expected %b", obs(), {VW{1'b0}});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed(input string name, input int unsigned x, input int unsigned y,
                               input logic s, input int unsigned m, input logic z);
    logic [VW-1:0] e;
    a        = x[WIDTH-1:0];
    b        = y[WIDTH-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    e = pack_exp(1'b1, s, z, m);
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, obs(), e);
    end
  endtask

  task automatic test_extreme_hold();
    logic [VW-1:0] e;
    test_directed("extreme_0_15", 0, 15, 1'b1, 15, 1'b0);
    in_valid = 1'b0;
    a        = 4'd7;
    b        = 4'd3;
    @(posedge clk); #1;
    e = pack_exp(1'b0, 1'b1, 1'b0, 15);
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL hold_idle: got %b expected %b", obs(), e);
    end
    a = 'x;
    b = 'x;
    @(posedge clk); #1;
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL hold_x_inputs: got %b expected %b", obs(), e);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] e;
    int            bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      e = model(a, b);
      @(posedge clk); #1;
      tests++;
      if (obs() !== e) begin
        fails++;
        if (bad++ < 10)
          $display("FAIL stream[%0d] a=%0d b=%0d: got %b expected %b", i, a, b, obs(), e);
      end
    end
  endtask

  task automatic test_random_gaps();
    logic [VW-1:0] e;
    logic [VW-1:0] last;
    int            bad = 0;
    last = obs();  // state left by the previous test, already checked there
    for (int i = 0; i < 150; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      if (in_valid) e = model(a, b);
      else          e = {1'b0, last[VW-2:0]};
      @(posedge clk); #1;
      tests++;
      if (obs() !== e) begin
        fails++;
        if (bad++ < 10)
          $display("FAIL gaps[%0d] v=%0b a=%0d b=%0d: got %b expected %b",
                   i, in_valid, a, b, obs(), e);
      end
      last = e;
    end
  endtask

  task automatic test_reset_mid_stream();
    in_valid = 1'b1;
    a        = 4'd13;
    b        = 4'd1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (obs() !== '0) begin
      fails++;
      $display("FAIL reset_mid_stream: got %b expected %b", obs(), {VW{1'b0}});
    end
    rst_n = 1'b1;
    test_directed("after_reset", 3, 8, 1'b1, 5, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    test_reset();
    test_directed("positive_10_6", 10, 6, 1'b0, 4, 1'b0);
    test_directed("negative_2_12", 2, 12, 1'b1, 10, 1'b0);
    test_directed("zero_10_10", 10, 10, 1'b0, 0, 1'b1);
    test_directed("max_15_0", 15, 0, 1'b0, 15, 1'b0);
    test_extreme_hold();
    test_back_to_back();
    test_random_gaps();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/subtractor.md
Name: subtractor

Overview:
- Registered unsigned subtractor with a sign-magnitude result: computes |a - b| and flags a negative difference.
- Arithmetic datapath leaf block. Operands arrive with a valid strobe; the result and sign are registered one cycle later.
- Default width is 4 bits and is parameterizable.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a and b are valid this cycle.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  result and sign hold a new value.
- result  output  WIDTH  magnitude |a - b|, unsigned.
- sign  output  1  1 when a < b (difference is negative), else 0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n is 0, result = 0, sign = 0, out_valid = 0, regardless of clk. Reset applies immediately on assertion. It is released synchronously, and the first capture happens on the first clk edge after rst_n rises.
- Operands are treated as unsigned. Compute the raw difference d = a - b in WIDTH+1 bits; the extra top bit is the borrow.
- If the borrow is 0: result = d[WIDTH-1:0], sign = 0.
- If the borrow is 1: result = b - a (two's complement of d, truncated to WIDTH), sign = 1.
- a == b: result = 0, sign = 0. There is no negative zero.
- Extremes: a = 0, b = 2^WIDTH-1 gives result = 2^WIDTH-1, sign = 1. No overflow is possible, because the magnitude always fits in WIDTH bits.
- Latency: exactly 1 cycle. If in_valid is 1 at edge N, outputs reflect that operand pair after edge N and out_valid = 1.
- If in_valid is 0 at an edge: out_valid goes to 0, and result and sign hold their previous values.
- Back-to-back in_valid: one result per cycle. There is no stall and no backpressure.
- Reset asserted mid-stream: the pending result is discarded and outputs return to reset values.
- X on a or b while in_valid = 0 must not propagate into result or sign.

Optional Feature:
- Macro: SUBTRACTOR_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit). zero is registered alongside result and is 1 when a == b for the captured pair. It resets to 0 and holds when in_valid = 0.
- Undefined: the port is absent and there is no extra logic. All other behaviour is identical.

Decomposition:
- Shared package subtractor_pkg holds:
  - localparam DEFAULT_WIDTH = 4;
  - typedef struct packed { logic sign; logic [WIDTH-1:0] mag; } sm_result_t, defined for the default width;
  - a function abs_diff(a, b) returning sm_result_t, for bench reference modelling.
- One combinational sub-module, abs_diff_comb, is natural. It is a borrow-chain subtractor producing the magnitude and the borrow. The top level keeps only the registers, the valid pipeline and the optional zero flag.

Test Plan:
- Reset: hold rst_n = 0 while toggling a and b -> result = 0, sign = 0, out_valid = 0. Assert rst_n asynchronously mid-cycle -> outputs clear immediately.
- Positive difference: a = 10, b = 6, in_valid = 1 -> next cycle result = 4, sign = 0, out_valid = 1.
- Negative difference: a = 2, b = 12 -> result = 10, sign = 1.
- Zero difference: a = 10, b = 10 -> result = 0, sign = 0; zero = 1 when SUBTRACTOR_ZERO_FLAG_EN is defined.
- Extremes and hold: a = 0, b = 15 -> result = 15, sign = 1. Then drop in_valid with a = 7, b = 3 -> out_valid = 0 and result stays 15.
- Streaming: random pairs with in_valid = 1 every cycle for 200 cycles -> each output matches abs_diff one cycle later, with no bubbles.
